// File: rtl/soc_system_dipsw_debounce.sv
// Per-bit two-flop synchronizer and stability-counter debouncer for board DIP switches.
// A new level reaches sw_out only after DEBOUNCE_CYCLES consecutive mismatching cycles at sync2.
module soc_system_dipsw_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_change,
  output logic             sw_valid
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Startup counter needs to reach DEBOUNCE_CYCLES+1, so give it headroom beyond CNT_WIDTH.
  localparam int                  ST_WIDTH = CNT_WIDTH + 2;
  localparam logic [ST_WIDTH-1:0] ST_LAST  = ST_WIDTH'(DEBOUNCE_CYCLES + 1);
  localparam logic [ST_WIDTH-1:0] ST_ONE   = ST_WIDTH'(1);

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];
  logic [ST_WIDTH-1:0]  start_cnt;

  // Synchronizer stages
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // Debounce stage: any matching cycle discards accumulated credit
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_out    <= '0;
      sw_change <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        sw_change[i] <= 1'b0;
        if (sync2[i] == sw_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          sw_out[i]    <= sync2[i];
          cnt[i]       <= '0;
          sw_change[i] <= sw_valid;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Startup window: valid rises on edge DEBOUNCE_CYCLES+2 after release, then the counter freezes
  always_ff @(posedge clk) begin
    if (reset) begin
      start_cnt <= '0;
      sw_valid  <= 1'b0;
    end else if (!sw_valid) begin
      start_cnt <= start_cnt + ST_ONE;
      if (start_cnt == ST_LAST) begin
        sw_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/soc_system_dipsw_debounce.md
# soc_system_dipsw_debounce

Per-bit synchronizer and debouncer for the board DIP switches. It sits directly upstream of the DIP-switch PIO: its `sw_out` bus drives the PIO's `in_port`. Raw asynchronous switch levels enter through a two-flop synchronizer, and only levels held stable for `DEBOUNCE_CYCLES` clocks reach the PIO. This keeps contact bounce from causing spurious edge captures and interrupts.

## Interface
- `WIDTH`, default 4: number of switch bits.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a new level (20 ms at 50 MHz). Must be ≥1.
- `CNT_WIDTH`, default 20: width of each per-bit counter. Must satisfy 2^CNT_WIDTH ≥ `DEBOUNCE_CYCLES`.
- `clk`  in  1: single clock; all state is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sw_in`  in  WIDTH: raw asynchronous switch levels.
- `sw_out`  out  WIDTH: debounced levels, registered; connects to PIO `in_port`.
- `sw_change`  out  WIDTH: one-cycle pulse per bit, asserted in the cycle `sw_out[i]` toggles, once valid.
- `sw_valid`  out  1: high once the startup window has elapsed; `sw_out` is meaningful from then on.

## Operation
- Reset (sampled on a `clk` edge with `reset`=1) clears all state:
  - `sync1`, `sync2`, `sw_out`, every counter, the startup counter, `sw_change` and `sw_valid` all go to 0.
- Synchronizer:
  - `sync1 <= sw_in`; `sync2 <= sync1`.
  - Only `sync2` is used downstream. Nothing samples `sw_in` directly.
- Per bit i, each edge with `reset`=0:
  - If `sync2[i] == sw_out[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_out[i] <= sync2[i]`, `cnt[i] <= 0`, `sw_change[i] <= sw_valid`.
  - Else: `cnt[i] <= cnt[i]+1`.
  - `sw_change[i]` is 0 in every other cycle.
- Glitch rejection: a single cycle in which `sync2[i]` matches `sw_out[i]` clears `cnt[i]`. The next mismatch restarts from 0, with no partial credit.
- Counters are unsigned. `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.
- Bits are fully independent. Simultaneous commits on several bits produce simultaneous `sw_change` bits.
- Startup:
  - A global counter counts edges after reset release.
  - `sw_valid` is set at edge number `DEBOUNCE_CYCLES+2` after release, the first edge after release being number 1. It stays high until the next reset.
  - Levels present at power-up are therefore adopted into `sw_out` with no `sw_change` pulse.
  - `sw_out` itself is never masked. The downstream PIO may still record power-up edges, and software clears them after `sw_valid`.
- Reset mid-debounce: in-progress counts are discarded, and `sw_out` returns to 0 on that edge.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Latency: if `sw_in[i]` changes and is first sampled at edge E1 and held, `sw_out[i]` and `sw_change[i]` update at edge E(`DEBOUNCE_CYCLES`+2).
  - Breakdown: 2 synchronizer stages, then `DEBOUNCE_CYCLES` mismatch cycles.
- Shorter pulses are rejected. Any level held less than `DEBOUNCE_CYCLES` cycles at `sync2` never reaches `sw_out`.
- `sw_change` width is exactly one cycle. The minimum spacing between pulses on one bit is `DEBOUNCE_CYCLES` cycles.
- `sw_valid` and `sw_out` update on the same edge for bits high at power-up.

## Test plan
Use `WIDTH`=4, `DEBOUNCE_CYCLES`=4, `CNT_WIDTH`=3.
1. **Power-up adoption.** Reset 2 cycles with `sw_in`=4'b1010, then release.
   - `sw_out`=0 through edge 5 after release.
   - At edge 6: `sw_out`=4'b1010 and `sw_valid`=1.
   - `sw_change` stays 0 throughout.
2. **Clean toggle.** After valid, `sw_in[0]` 0→1, first sampled at E1, then held.
   - `sw_out[0]`=1 and `sw_change`=4'b0001 at E6.
   - `sw_change`=0 at E7.
3. **Bounce rejection.** After valid, drive `sw_in[1]` with 1,1,1,0,1,1,1,0 per cycle (3 high, 1 low, repeated 4 times).
   - `sw_out[1]` never changes; `sw_change[1]` stays 0.
   - Then hold 1: `sw_out[1]` rises 6 edges after the last 0→1 sample.
4. **Simultaneous bits.** Change `sw_in[3:2]` 00→11 on the same cycle.
   - Both bits commit on the same edge, with `sw_change`=4'b1100 for one cycle.
5. **Reset mid-debounce.** Assert `reset` for 1 cycle, 2 cycles into a pending 0→1 on bit 0.
   - `sw_out`=0, `sw_valid`=0 and counters 0 on the next edge.
   - The startup sequence restarts as in scenario 1.
6. **Falling edge.** Drive `sw_in[0]` 1→0 after it is debounced high.
   - Symmetric to scenario 2: `sw_out[0]`=0 and `sw_change[0]`=1 at E6.
